// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
//   state_t   : arbiter FSM states
//   WORD_LSB  : lowest address bit that selects a word
//   same_word : true when two byte addresses hit the same memory word
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DEFER = 1'b1
    } state_t;

    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned MAX_ADDR_W = 64;

    // Callers zero-extend to MAX_ADDR_W; extension does not change equality.
    function automatic logic same_word(input logic [MAX_ADDR_W-1:0] a,
                                       input logic [MAX_ADDR_W-1:0] b);
        logic [MAX_ADDR_W-1:0] diff;
        diff = (a ^ b) >> WORD_LSB;
        return diff == '0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Lane request / memory port bundle between the execute lanes and the arbiter.
//   slave  : arbiter side (takes lane requests, drives memory ports and status)
//   master : environment side (drives lane requests, observes memory ports)
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  flush;
    logic                  reqA_valid;
    logic                  reqA_write;
    logic [DATA_WIDTH-1:0] reqA_addr;
    logic [DATA_WIDTH-1:0] reqA_wdata;
    logic                  reqB_valid;
    logic                  reqB_write;
    logic [DATA_WIDTH-1:0] reqB_addr;
    logic [DATA_WIDTH-1:0] reqB_wdata;
    logic [DATA_WIDTH-1:0] rd_addrA;
    logic [DATA_WIDTH-1:0] rd_addrB;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  fwdB;
    logic                  stall;
    logic [CNT_WIDTH-1:0]  conflict_cnt;

    modport slave (
        input  flush, reqA_valid, reqA_write, reqA_addr, reqA_wdata,
               reqB_valid, reqB_write, reqB_addr, reqB_wdata,
        output rd_addrA, rd_addrB, wr_en, wr_addr, wr_data, fwdB, stall,
               conflict_cnt
    );

    modport master (
        output flush, reqA_valid, reqA_write, reqA_addr, reqA_wdata,
               reqB_valid, reqB_write, reqB_addr, reqB_wdata,
        input  rd_addrA, rd_addrB, wr_en, wr_addr, wr_data, fwdB, stall,
               conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk, rst_n : clock, async active-low reset (clears count)
//   inc        : add one this cycle unless already saturated
//   count      : current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Schedules lane A (older) and lane B (younger) onto a data memory with two
// combinational read ports and one synchronous write port. Dual stores are
// split over two cycles with a one-cycle stall; store(A)->load(B) to the same
// word raises fwdB. All bus outputs are combinational from state and inputs.
//   clk, rst_n : clock, async active-low reset
//   bus        : lane requests, flush, memory ports, stall/fwdB, conflict_cnt
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned DW = DATA_WIDTH;

    state_t          state_q, state_d;
    logic [DW-1:0]   pend_addr_q, pend_addr_d;
    logic [DW-1:0]   pend_data_q, pend_data_d;

    logic            wr_en_c;
    logic [DW-1:0]   wr_addr_c;
    logic [DW-1:0]   wr_data_c;
    logic            stall_c;
    logic            fwd_b_c;
    logic            conflict_inc_c;
    logic            a_store_c;
    logic            b_store_c;
    logic            b_load_c;
    logic            ab_same_word_c;

    assign a_store_c      = bus.reqA_valid &&  bus.reqA_write;
    assign b_store_c      = bus.reqB_valid &&  bus.reqB_write;
    assign b_load_c       = bus.reqB_valid && !bus.reqB_write;
    assign ab_same_word_c = same_word(MAX_ADDR_W'(bus.reqA_addr),
                                      MAX_ADDR_W'(bus.reqB_addr));

    // Next-state, pending capture and port drive.
    always_comb begin
        state_d        = state_q;
        pend_addr_d    = pend_addr_q;
        pend_data_d    = pend_data_q;
        wr_en_c        = 1'b0;
        wr_addr_c      = '0;
        wr_data_c      = '0;
        stall_c        = 1'b0;
        fwd_b_c        = 1'b0;
        conflict_inc_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_store_c && b_store_c) begin
                    wr_en_c        = 1'b1;
                    wr_addr_c      = bus.reqA_addr;
                    wr_data_c      = bus.reqA_wdata;
                    stall_c        = 1'b1;
                    pend_addr_d    = bus.reqB_addr;
                    pend_data_d    = bus.reqB_wdata;
                    conflict_inc_c = 1'b1;
                    state_d        = DEFER;
                end else if (a_store_c) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = bus.reqA_addr;
                    wr_data_c = bus.reqA_wdata;
                    fwd_b_c   = b_load_c && ab_same_word_c;
                end else if (b_store_c) begin
                    // Older lane-A load reads the pre-store value; nothing to do.
                    wr_en_c   = 1'b1;
                    wr_addr_c = bus.reqB_addr;
                    wr_data_c = bus.reqB_wdata;
                end
            end
            DEFER: begin
                // Lane inputs still hold the stalled bundle and are ignored.
                if (!bus.flush) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = pend_addr_q;
                    wr_data_c = pend_data_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset is asynchronous, so the combinational outputs must drop with it.
        if (!rst_n) begin
            wr_en_c        = 1'b0;
            stall_c        = 1'b0;
            fwd_b_c        = 1'b0;
            conflict_inc_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (conflict_inc_c),
        .count (bus.conflict_cnt)
    );

    assign bus.rd_addrA = bus.reqA_addr;
    assign bus.rd_addrB = bus.reqB_addr;
    assign bus.wr_en    = wr_en_c;
    assign bus.wr_addr  = wr_addr_c;
    assign bus.wr_data  = wr_data_c;
    assign bus.stall    = stall_c;
    assign bus.fwdB     = fwd_b_c;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a small word memory
// attached to its ports. The driver pushes one expectation per cycle; the
// monitor pops and compares on the falling edge.
module tb_mem_port_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef struct {
        logic          rst_n;
        logic          flush;
        logic          av;
        logic          aw;
        logic [DW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic          bw;
        logic [DW-1:0] ba;
        logic [DW-1:0] bd;
    } stim_t;

    typedef struct {
        string         name;
        logic          wr_en;
        logic [DW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          stall;
        logic          fwdb;
        logic [CW-1:0] cnt;
        logic          chk_a;
        logic [DW-1:0] rda;
        logic          chk_b;
        logic [DW-1:0] rdb;
        logic [DW-1:0] pa;
        logic [DW-1:0] pb;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t cur;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational reads, write commits on the rising edge.
    assign rd_data_a = mem[bus.rd_addrA[9:2]];
    assign rd_data_b = mem[bus.rd_addrB[9:2]];
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr[9:2]] <= bus.wr_data;
    end

    function automatic stim_t S(input logic r, input logic f,
                                input logic av, input logic aw,
                                input logic [DW-1:0] aa, input logic [DW-1:0] ad,
                                input logic bv, input logic bw,
                                input logic [DW-1:0] ba, input logic [DW-1:0] bd);
        stim_t s;
        s.rst_n = r; s.flush = f;
        s.av = av; s.aw = aw; s.aa = aa; s.ad = ad;
        s.bv = bv; s.bw = bw; s.ba = ba; s.bd = bd;
        return s;
    endfunction

    function automatic exp_t E(input string n, input logic we,
                               input logic [DW-1:0] wa, input logic [DW-1:0] wd,
                               input logic st, input logic fw, input logic [CW-1:0] c,
                               input logic ca, input logic [DW-1:0] ra,
                               input logic cb, input logic [DW-1:0] rb);
        exp_t e;
        e.name = n; e.wr_en = we; e.wr_addr = wa; e.wr_data = wd;
        e.stall = st; e.fwdb = fw; e.cnt = c;
        e.chk_a = ca; e.rda = ra; e.chk_b = cb; e.rdb = rb;
        e.pa = '0; e.pb = '0;
        return e;
    endfunction

    task automatic step(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst_n          = s.rst_n;
        bus.flush      = s.flush;
        bus.reqA_valid = s.av;
        bus.reqA_write = s.aw;
        bus.reqA_addr  = s.aa;
        bus.reqA_wdata = s.ad;
        bus.reqB_valid = s.bv;
        bus.reqB_write = s.bw;
        bus.reqB_addr  = s.ba;
        bus.reqB_wdata = s.bd;
        e.pa = s.aa;
        e.pb = s.ba;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, want);
        end
    endtask

    // Monitor: one expectation per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk({cur.name, ".wr_en"}, DW'(bus.wr_en), DW'(cur.wr_en));
            if (cur.wr_en) begin
                chk({cur.name, ".wr_addr"}, bus.wr_addr, cur.wr_addr);
                chk({cur.name, ".wr_data"}, bus.wr_data, cur.wr_data);
            end
            chk({cur.name, ".stall"}, DW'(bus.stall), DW'(cur.stall));
            chk({cur.name, ".fwdB"}, DW'(bus.fwdB), DW'(cur.fwdb));
            chk({cur.name, ".cnt"}, DW'(bus.conflict_cnt), DW'(cur.cnt));
            chk({cur.name, ".rd_addrA"}, bus.rd_addrA, cur.pa);
            chk({cur.name, ".rd_addrB"}, bus.rd_addrB, cur.pb);
            if (cur.chk_a) chk({cur.name, ".rdA"}, rd_data_a, cur.rda);
            if (cur.chk_b) chk({cur.name, ".rdB"}, rd_data_b, cur.rdb);
        end
    end

    initial begin
        stim_t ds;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.reqA_valid = 1'b0;
        bus.reqA_write = 1'b0;
        bus.reqA_addr  = '0;
        bus.reqA_wdata = '0;
        bus.reqB_valid = 1'b0;
        bus.reqB_write = 1'b0;
        bus.reqB_addr  = '0;
        bus.reqB_wdata = '0;

        // Reset gates outputs even with a store presented.
        step(S(0,0, 1,1,32'h100,32'h5, 0,0,0,0),
             E("reset", 0,0,0, 0,0,0, 0,0, 0,0));
        step(S(1,0, 0,0,0,0, 0,0,0,0),
             E("idle", 0,0,0, 0,0,0, 0,0, 0,0));
        // Single store, then read back.
        step(S(1,0, 1,1,32'h100,32'hDEADBEEF, 1,0,32'h200,0),
             E("single", 1,32'h100,32'hDEADBEEF, 0,0,0, 0,0, 0,0));
        step(S(1,0, 1,0,32'h100,0, 0,0,0,0),
             E("single_rd", 0,0,0, 0,0,0, 1,32'hDEADBEEF, 0,0));
        // Forwarding: same word and different word.
        step(S(1,0, 1,1,32'h104,32'h11, 1,0,32'h106,0),
             E("fwd_same", 1,32'h104,32'h11, 0,1,0, 0,0, 0,0));
        step(S(1,0, 1,1,32'h104,32'h11, 1,0,32'h108,0),
             E("fwd_diff", 1,32'h104,32'h11, 0,0,0, 0,0, 0,0));
        // B store + older A load of same word: A sees old data, no forward.
        step(S(1,0, 1,0,32'h104,0, 1,1,32'h104,32'h22),
             E("b_store_a_load", 1,32'h104,32'h22, 0,0,0, 1,32'h11, 0,0));
        // Dual store, different words.
        ds = S(1,0, 1,1,32'h10,32'hA, 1,1,32'h20,32'hB);
        step(ds, E("dual_c0", 1,32'h10,32'hA, 1,0,0, 0,0, 0,0));
        step(ds, E("dual_c1", 1,32'h20,32'hB, 0,0,1, 0,0, 0,0));
        step(S(1,0, 1,0,32'h20,0, 1,0,32'h10,0),
             E("dual_rd", 0,0,0, 0,0,1, 1,32'hB, 1,32'hA));
        // Dual store, same word: B lands last.
        ds = S(1,0, 1,1,32'h30,32'hA, 1,1,32'h30,32'hB);
        step(ds, E("same_c0", 1,32'h30,32'hA, 1,0,1, 0,0, 0,0));
        step(ds, E("same_c1", 1,32'h30,32'hB, 0,0,2, 0,0, 0,0));
        step(S(1,0, 1,0,32'h30,0, 0,0,0,0),
             E("same_rd", 0,0,0, 0,0,2, 1,32'hB, 0,0));
        // Flush in DEFER drops the B write.
        ds = S(1,0, 1,1,32'h40,32'h1, 1,1,32'h50,32'h2);
        step(ds, E("flush_c0", 1,32'h40,32'h1, 1,0,2, 0,0, 0,0));
        ds.flush = 1'b1;
        step(ds, E("flush_c1", 0,0,0, 0,0,3, 0,0, 0,0));
        step(S(1,0, 1,0,32'h50,0, 1,0,32'h40,0),
             E("flush_rd", 0,0,0, 0,0,3, 1,32'h0, 1,32'h1));
        // Flush has no effect in IDLE.
        step(S(1,1, 1,1,32'h60,32'h6, 0,0,0,0),
             E("flush_idle", 1,32'h60,32'h6, 0,0,3, 0,0, 0,0));
        // Reset in DEFER drops the B write and clears the counter.
        ds = S(1,0, 1,1,32'h70,32'h7, 1,1,32'h74,32'h8);
        step(ds, E("rst_c0", 1,32'h70,32'h7, 1,0,3, 0,0, 0,0));
        ds.rst_n = 1'b0;
        step(ds, E("rst_c1", 0,0,0, 0,0,0, 0,0, 0,0));
        step(S(1,0, 1,0,32'h74,0, 1,0,32'h70,0),
             E("rst_rd", 0,0,0, 0,0,0, 1,32'h0, 1,32'h7));
        // Saturation: 20 dual stores on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            ds = S(1,0, 1,1,32'h80,32'(i), 1,1,32'h84,~32'(i));
            step(ds, E("sat_c0", 1,32'h80,32'(i), 1,0,
                       CW'((i < 15) ? i : 15), 0,0, 0,0));
            step(ds, E("sat_c1", 1,32'h84,~32'(i), 0,0,
                       CW'((i + 1 < 15) ? i + 1 : 15), 0,0, 0,0));
        end
        step(S(1,0, 1,0,32'h84,0, 1,0,32'h80,0),
             E("sat_end", 0,0,0, 0,0,4'hF, 1,~32'd19, 1,32'd19));

        repeat (2) @(negedge clk);
        #1;
        chk("drain", DW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Schedules the two issue lanes (A = older, B = younger in program order) onto the data memory. The memory has two combinational read ports and one synchronous write port.
- Sits between the execute-stage lane outputs and the data memory in the memory stage.
- Serialises dual stores over two cycles and stalls the pipeline for the extra cycle.
- Flags same-cycle store(A)→load(B) same-word forwarding.
- Keeps a saturating count of conflict stall cycles.

Parameters:
DATA_WIDTH, 32, data and address width
CNT_WIDTH, 16, width of the conflict-stall counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  squash the deferred lane-B store
reqA_valid  input  1  lane A has a memory op
reqA_write  input  1  lane A op is a store (0 = load)
reqA_addr  input  DATA_WIDTH  lane A byte address
reqA_wdata  input  DATA_WIDTH  lane A store data
reqB_valid, reqB_write, reqB_addr, reqB_wdata  input  1/1/DATA_WIDTH/DATA_WIDTH  same fields for lane B
rd_addrA  output  DATA_WIDTH  read-port A address (= reqA_addr)
rd_addrB  output  DATA_WIDTH  read-port B address (= reqB_addr)
wr_en  output  1  write-port enable
wr_addr  output  DATA_WIDTH  write-port address
wr_data  output  DATA_WIDTH  write-port data
fwdB  output  1  lane B result must take reqA_wdata instead of the read-port B data
stall  output  1  hold upstream registers and lane inputs this cycle
conflict_cnt  output  CNT_WIDTH  number of stall cycles, saturating

Behaviour:
- Word compare: addresses match when addr[DATA_WIDTH-1:2] are equal. Word accesses only.
- States: IDLE, DEFER.
- All outputs are driven combinationally from the state and the inputs.
- Reset (rst_n=0, asynchronous): state=IDLE, pending regs=0, conflict_cnt=0. While in reset, wr_en=0, stall=0, fwdB=0.
- rd_addrA and rd_addrB always pass the lane addresses straight through. Loads have zero added latency.
- IDLE, no valid store: wr_en=0, stall=0.
- IDLE, exactly one valid store (lane A or lane B):
  - wr_en=1, wr_addr/wr_data taken from that lane; the write commits at the next edge.
  - stall=0.
- IDLE, A store + B load, same word: fwdB=1 (B must see A's data). Otherwise fwdB=0.
- IDLE, B store + A load, same word: no action. A is older and reads the old value.
- IDLE, both lanes are valid stores:
  - Write A now (wr_en=1, A fields); stall=1.
  - Capture reqB_addr/reqB_wdata into the pending regs; next state = DEFER.
  - conflict_cnt += 1.
- DEFER:
  - wr_en=1 with the pending B fields; stall=0; fwdB=0; next state = IDLE.
  - The lane inputs are still the held bundle and are ignored; read ports keep passing through.
  - Same-word A/B stores: B is written last, so B's data wins.
- flush while in DEFER: wr_en=0, next state = IDLE, pending write dropped. flush has no effect in IDLE.
- Reset asserted in DEFER: the pending write is dropped and no write is issued.
- conflict_cnt saturates at all-ones and does not wrap.
- After a dual store, the next bundle is accepted in the cycle after DEFER. There are no back-to-back DEFERs without an intervening IDLE cycle.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, DEFER}
  - WORD_LSB = 2
  - function same_word(a, b)
- Sub-module sat_counter (parameter WIDTH; inputs clk, rst_n, inc; output count): a saturating up-counter, instantiated for conflict_cnt.
- Everything else stays in mem_port_arbiter.

Test Plan:
- Reset then idle: rst_n=0 → all outputs 0, conflict_cnt=0. Release, apply no requests → wr_en=0, stall=0.
- Single store: A store addr=0x100, data=0xDEADBEEF; B load addr=0x200 → wr_en=1, wr_addr=0x100, stall=0, fwdB=0. Next cycle, a load of 0x100 returns 0xDEADBEEF.
- Forward: A store 0x104=0x11, B load 0x106 (same word) → fwdB=1, wr_en=1, wr_addr=0x104. A store 0x104 with B load 0x108 → fwdB=0.
- Dual store:
  - A 0x10=0xA, B 0x20=0xB.
  - Cycle 0: wr 0x10/0xA, stall=1.
  - Cycle 1: wr 0x20/0xB, stall=0, conflict_cnt=1.
  - Same-word variant: A 0x10=0xA, B 0x10=0xB → the final memory word is 0xB.
- Flush and reset abort: a dual store with flush=1 in the DEFER cycle → wr_en=0, 0x20 unchanged, state IDLE. Repeat with rst_n pulsed low in DEFER → no B write, conflict_cnt=0.
- Saturation: CNT_WIDTH=4, issue 20 dual stores → conflict_cnt stays at 15.
